// File: rtl/oled_init_seq_if.sv
// Byte stream channel from the OLED init sequencer to the serial byte writer.
// A byte transfers on any cycle where cmd_valid and cmd_ready are both high.
interface oled_init_seq_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_dc;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_data, output cmd_dc, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, input cmd_dc, output cmd_ready);
endinterface

// File: rtl/oled_init_seq.sv
// SSD1306 128x64 init sequencer: optional panel reset pulse, then the fixed command table.
// Define OLED_INIT_RESET_PULSE_EN to include the reset-low / settle phase before the table.
module oled_init_seq #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned RST_LOW_US  = 10,
  parameter int unsigned RST_WAIT_US = 100,
  parameter int unsigned CMD_NUM     = 25
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             init_req,
  output logic             init_finish,
  output logic             oled_res_n,
  oled_init_seq_if.master  cmd
);

  localparam int unsigned IW = 5;
  localparam logic [IW-1:0] LAST_IDX = IW'(CMD_NUM - 1);

  if (CMD_NUM < 1 || CMD_NUM > 25 || CLK_FREQ_HZ < 1000000 ||
      RST_LOW_US < 1 || RST_WAIT_US < 1) begin : g_bad_cfg
    $error("oled_init_seq: illegal parameter set");
  end

`ifdef OLED_INIT_RESET_PULSE_EN
  localparam int unsigned T_LOW  = RST_LOW_US  * (CLK_FREQ_HZ / 1000000);
  localparam int unsigned T_WAIT = RST_WAIT_US * (CLK_FREQ_HZ / 1000000);
  localparam int unsigned TW     = $clog2(T_WAIT + 1);
  localparam logic [TW-1:0] T_LOW_LAST  = TW'(T_LOW - 1);
  localparam logic [TW-1:0] T_WAIT_LAST = TW'(T_WAIT - 1);

  typedef enum logic [2:0] {IDLE, RST_LOW, RST_WAIT, SEND, DONE} state_t;
  logic [TW-1:0] timer;
`else
  typedef enum logic [2:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t        state;
  logic [IW-1:0] index;

  function automatic logic [7:0] cmd_byte(input logic [IW-1:0] i);
    case (i)
      5'd0:  return 8'hAE;  5'd1:  return 8'hD5;  5'd2:  return 8'h80;
      5'd3:  return 8'hA8;  5'd4:  return 8'h3F;  5'd5:  return 8'hD3;
      5'd6:  return 8'h00;  5'd7:  return 8'h40;  5'd8:  return 8'h8D;
      5'd9:  return 8'h14;  5'd10: return 8'h20;  5'd11: return 8'h00;
      5'd12: return 8'hA1;  5'd13: return 8'hC8;  5'd14: return 8'hDA;
      5'd15: return 8'h12;  5'd16: return 8'h81;  5'd17: return 8'hCF;
      5'd18: return 8'hD9;  5'd19: return 8'hF1;  5'd20: return 8'hDB;
      5'd21: return 8'h40;  5'd22: return 8'hA4;  5'd23: return 8'hA6;
      5'd24: return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction

`ifndef OLED_INIT_RESET_PULSE_EN
  assign oled_res_n = 1'b1;
`endif

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      index         <= '0;
      init_finish   <= 1'b0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_data  <= '0;
      cmd.cmd_dc    <= 1'b0;
`ifdef OLED_INIT_RESET_PULSE_EN
      timer         <= '0;
      oled_res_n    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (init_req) begin
            index <= '0;
`ifdef OLED_INIT_RESET_PULSE_EN
            state      <= RST_LOW;
            timer      <= '0;
            oled_res_n <= 1'b0;
`else
            state         <= SEND;
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_data  <= cmd_byte('0);
`endif
          end
        end
`ifdef OLED_INIT_RESET_PULSE_EN
        RST_LOW: begin
          if (!init_req) begin
            state      <= IDLE;
            timer      <= '0;
            oled_res_n <= 1'b1;
          end else if (timer == T_LOW_LAST) begin
            state      <= RST_WAIT;
            timer      <= '0;
            oled_res_n <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RST_WAIT: begin
          if (!init_req) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == T_WAIT_LAST) begin
            state         <= SEND;
            timer         <= '0;
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_data  <= cmd_byte('0);
          end else begin
            timer <= timer + TW'(1);
          end
        end
`endif
        SEND: begin
          // A dropped request only takes effect once the presented byte has been accepted.
          if (cmd.cmd_ready) begin
            if (!init_req) begin
              state         <= IDLE;
              cmd.cmd_valid <= 1'b0;
            end else if (index == LAST_IDX) begin
              state         <= DONE;
              cmd.cmd_valid <= 1'b0;
              init_finish   <= 1'b1;
            end else begin
              index        <= index + IW'(1);
              cmd.cmd_data <= cmd_byte(index + IW'(1));
            end
          end
        end
        DONE: begin
          if (!init_req) begin
            state       <= IDLE;
            init_finish <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/oled_init_seq.md
Name: oled_init_seq

Overview:
- Responder to the OLED top-level sequencer's init phase.
- While `init_req` is high, the block optionally pulses the panel reset pin, then streams a fixed SSD1306 128x64 command table over a byte valid/ready interface to the serial byte writer.
- When the last byte is accepted it asserts `init_finish` and holds it for as long as `init_req` stays high.

Parameters:
- CLK_FREQ_HZ, 50000000, clock frequency in Hz; used for the reset timing counts.
- RST_LOW_US, 10, panel reset low time in microseconds.
- RST_WAIT_US, 100, settle time after reset release, in microseconds.
- CMD_NUM, 25, number of table entries sent. Legal range is 1..25; higher indices are never read.

Ports:
- clk_50m  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- init_req  in  1  level request from the top sequencer; held high until `init_finish` is seen.
- init_finish  out  1  sequence complete; level signal.
- oled_res_n  out  1  panel hardware reset pin, active low.
- cmd_valid  out  1  byte available to the writer.
- cmd_data  out  8  command byte.
- cmd_dc  out  1  data/command select; always 0 (command) from this block.
- cmd_ready  in  1  writer accepts a byte. A transfer occurs on a cycle where `cmd_valid` and `cmd_ready` are both 1.

Behaviour:
- Reset: one clock (`clk_50m`); `rst_n` is asynchronous, active-low. All outputs are registered. Reset values:
  - state=IDLE, index=0, timer=0
  - init_finish=0, oled_res_n=1, cmd_valid=0, cmd_data=8'h00, cmd_dc=0
- Timing constants:
  - T_LOW = RST_LOW_US*(CLK_FREQ_HZ/1000000) = 500 cycles.
  - T_WAIT = RST_WAIT_US*(CLK_FREQ_HZ/1000000) = 5000 cycles.
  - Timer width is $clog2(T_WAIT+1).
- Command table (index 0..24): AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
- States:
  - IDLE:
    - init_req=1 -> RST_LOW (see Optional Feature); timer=0, index=0.
    - Otherwise stay.
  - RST_LOW:
    - oled_res_n=0.
    - When timer==T_LOW-1 -> RST_WAIT, timer=0, oled_res_n=1.
  - RST_WAIT:
    - oled_res_n=1.
    - When timer==T_WAIT-1 -> SEND; cmd_valid=1 and cmd_data=table[0] in the same registered update.
  - SEND:
    - cmd_valid=1, cmd_data=table[index].
    - On a transfer with index<CMD_NUM-1: index+1, and the next byte is presented the following cycle. cmd_valid stays 1, giving back-to-back transfers when cmd_ready is held high.
    - On a transfer with index==CMD_NUM-1: cmd_valid=0, init_finish=1 -> DONE.
    - cmd_data and cmd_valid never change while cmd_valid=1 and cmd_ready=0.
  - DONE:
    - init_finish=1.
    - init_req=0 -> IDLE with init_finish=0 on the next cycle. Re-raising init_req later restarts from index 0.
- Latency:
  - First cmd_valid goes high T_LOW+T_WAIT+1 cycles after the first cycle init_req is sampled high.
  - init_finish goes high the cycle after the last transfer.
- init_req deasserted mid-sequence:
  - RST_LOW/RST_WAIT: abort immediately to IDLE; oled_res_n=1, timer=0.
  - SEND: finish the pending byte (hold until its transfer), then IDLE with cmd_valid=0. No further bytes are sent and init_finish is not asserted.
- cmd_ready high while cmd_valid=0 is ignored.
- Asynchronous reset mid-operation returns to the reset values at once; oled_res_n=1 and cmd_valid=0.

Optional Feature:
- Macro: OLED_INIT_RESET_PULSE_EN.
- Defined: IDLE -> RST_LOW -> RST_WAIT -> SEND as described above.
- Undefined:
  - RST_LOW/RST_WAIT logic and the timer are not compiled; oled_res_n is constant 1.
  - IDLE with init_req=1 goes directly to SEND; cmd_valid=1 with table[0] on the next cycle.

Test Plan:
- Macro defined, reset released, init_req=1, cmd_ready=1:
  - oled_res_n low for exactly 500 cycles, then high.
  - cmd_valid rises 5000 cycles later.
  - 25 consecutive transfers AE..AF in table order, cmd_dc=0 throughout.
  - init_finish=1 the cycle after the AF transfer.
- Backpressure: cmd_ready toggled pseudo-randomly during SEND -> cmd_data/cmd_valid stable while stalled; no byte dropped or duplicated; byte count exactly 25.
- Drop init_req while in DONE -> init_finish=0 next cycle. Raise init_req again -> full sequence repeats from AE.
- Drop init_req during RST_LOW (cycle 200) -> oled_res_n=1 next cycle, state IDLE, no cmd_valid.
- Drop init_req during SEND at index 5 with cmd_ready=0:
  - byte D3 held until cmd_ready=1, then cmd_valid=0.
  - init_finish stays 0.
- Assert rst_n=0 at index 12 -> all outputs return to reset values immediately. Macro undefined: oled_res_n=1 always, and cmd_valid=1 one cycle after init_req rises.
